// File: rtl/fb_arbiter_pkg.sv
// Shared framebuffer types and geometry for the game, VGA and arbiter blocks.
package fb_arbiter_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned FB_DEPTH  = 76800;
  localparam int unsigned FB_ADDR_W = 19;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2
  } State;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10,
    WALL  = 2'b11
  } fb_pixel_t;

  // Read-return tag: which requester owns an in-flight read
  typedef enum logic [1:0] {
    NONE = 2'd0,
    VGA  = 2'd1,
    CA   = 2'd2,
    CB   = 2'd3
  } fb_owner_t;

endpackage

// File: rtl/fb_rr_pick.sv
// Two-way round-robin picker; the pointer moves past the client that just transferred.
module fb_rr_pick (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       xfer,
  output logic [1:0] gnt
);

  logic r_ptr_b;

  always_comb begin
    gnt = 2'b00;
    if (req_a && (!req_b || !r_ptr_b)) begin
      gnt = 2'b01;
    end else if (req_b) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr_b <= 1'b0;
    end else if (xfer) begin
      r_ptr_b <= gnt[0];
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scanout first, clients A/B round-robin,
// with a starvation guard that forces a waiting client past VGA.
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int unsigned FB_DEPTH     = fb_arbiter_pkg::FB_DEPTH,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 vga_req,
  input  logic [FB_ADDR_W-1:0] vga_addr,
  output logic                 vga_rvalid,
  output logic [1:0]           vga_rdata,
  output logic                 vga_miss,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [FB_ADDR_W-1:0] a_addr,
  input  logic [1:0]           a_wdata,
  output logic                 a_ready,
  output logic                 a_rvalid,
  output logic [1:0]           a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [FB_ADDR_W-1:0] b_addr,
  input  logic [1:0]           b_wdata,
  output logic                 b_ready,
  output logic                 b_rvalid,
  output logic [1:0]           b_rdata,
  output logic [FB_ADDR_W-1:0] ram_address,
  output logic                 ram_write_enabled,
  output logic [1:0]           ram_write_data,
  input  logic [1:0]           ram_read_data
);

  localparam int unsigned           SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]         STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [FB_ADDR_W-1:0]  ADDR_END   = FB_ADDR_W'(FB_DEPTH);

  logic [SW-1:0]        r_starve;
  logic [1:0]           w_gnt;
  logic                 w_pend, w_force, w_client_win, w_vga_go, w_vga_drop;
  logic                 w_a_xfer, w_b_xfer, w_go, w_we;
  logic [FB_ADDR_W-1:0] w_addr;
  logic [1:0]           w_wdata, w_ret;
  fb_owner_t            w_owner;

  fb_owner_t            r_tag1, r_tag2;
  logic                 r_oor1, r_oor2, r_miss1, r_miss2;
  logic [FB_ADDR_W-1:0] r_ram_addr;
  logic                 r_ram_we;
  logic [1:0]           r_ram_wdata;
  logic                 r_vga_rvalid, r_a_rvalid, r_b_rvalid, r_vga_miss;
  logic [1:0]           r_vga_rdata, r_a_rdata, r_b_rdata;

  fb_rr_pick u_rr_pick (
    .clock (clock),
    .reset (reset),
    .req_a (a_req),
    .req_b (b_req),
    .xfer  (w_a_xfer || w_b_xfer),
    .gnt   (w_gnt)
  );

  assign w_pend       = a_req || b_req;
  assign w_force      = w_pend && (r_starve == STARVE_MAX);
  assign w_client_win = w_pend && (!vga_req || w_force);
  assign w_vga_go     = vga_req && !w_force;
  assign w_vga_drop   = vga_req && w_force;
  assign a_ready      = !reset && w_client_win && w_gnt[0];
  assign b_ready      = !reset && w_client_win && w_gnt[1];
  assign w_a_xfer     = a_req && a_ready;
  assign w_b_xfer     = b_req && b_ready;

  always_comb begin
    w_go    = 1'b0;
    w_we    = 1'b0;
    w_addr  = vga_addr;
    w_wdata = 2'b00;
    w_owner = NONE;
    if (w_a_xfer) begin
      w_go    = 1'b1;
      w_we    = a_we;
      w_addr  = a_addr;
      w_wdata = a_wdata;
      w_owner = a_we ? NONE : CA;
    end else if (w_b_xfer) begin
      w_go    = 1'b1;
      w_we    = b_we;
      w_addr  = b_addr;
      w_wdata = b_wdata;
      w_owner = b_we ? NONE : CB;
    end else if (w_vga_go) begin
      w_go    = 1'b1;
      w_owner = VGA;
    end
  end

  // Out-of-range reads return EMPTY rather than whatever the RAM drives
  assign w_ret = r_oor2 ? 2'b00 : ram_read_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve     <= '0;
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_wdata  <= 2'b00;
      r_tag1       <= NONE;
      r_tag2       <= NONE;
      r_oor1       <= 1'b0;
      r_oor2       <= 1'b0;
      r_miss1      <= 1'b0;
      r_miss2      <= 1'b0;
      r_vga_rvalid <= 1'b0;
      r_a_rvalid   <= 1'b0;
      r_b_rvalid   <= 1'b0;
      r_vga_miss   <= 1'b0;
      r_vga_rdata  <= 2'b00;
      r_a_rdata    <= 2'b00;
      r_b_rdata    <= 2'b00;
    end else begin
      if (w_a_xfer || w_b_xfer || !w_pend) begin
        r_starve <= '0;
      end else if (r_starve != STARVE_MAX) begin
        r_starve <= r_starve + 1'b1;
      end
      if (w_go) begin
        r_ram_addr  <= w_addr;
        r_ram_wdata <= w_wdata;
      end
      r_ram_we     <= w_go && w_we && (w_addr < ADDR_END);
      r_tag1       <= w_owner;
      r_oor1       <= w_addr >= ADDR_END;
      r_miss1      <= w_vga_drop;
      r_tag2       <= r_tag1;
      r_oor2       <= r_oor1;
      r_miss2      <= r_miss1;
      r_vga_rvalid <= r_tag2 == VGA;
      r_a_rvalid   <= r_tag2 == CA;
      r_b_rvalid   <= r_tag2 == CB;
      r_vga_miss   <= r_miss2;
      if (r_tag2 == VGA) r_vga_rdata <= w_ret;
      if (r_tag2 == CA)  r_a_rdata   <= w_ret;
      if (r_tag2 == CB)  r_b_rdata   <= w_ret;
    end
  end

  assign ram_address       = r_ram_addr;
  assign ram_write_enabled = r_ram_we;
  assign ram_write_data    = r_ram_wdata;
  assign vga_rvalid        = r_vga_rvalid;
  assign vga_rdata         = r_vga_rdata;
  assign vga_miss          = r_vga_miss;
  assign a_rvalid          = r_a_rvalid;
  assign a_rdata           = r_a_rdata;
  assign b_rvalid          = r_b_rvalid;
  assign b_rdata           = r_b_rdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboarded bench for fb_arbiter: stimulus pushes expected read returns,
// a forked monitor pops them whenever an rvalid or vga_miss appears.
module tb_fb_arbiter;

  logic        clock, reset;
  logic        vga_req, vga_rvalid, vga_miss;
  logic [18:0] vga_addr;
  logic [1:0]  vga_rdata;
  logic        a_req, a_we, a_ready, a_rvalid;
  logic [18:0] a_addr;
  logic [1:0]  a_wdata, a_rdata;
  logic        b_req, b_we, b_ready, b_rvalid;
  logic [18:0] b_addr;
  logic [1:0]  b_wdata, b_rdata;
  logic [18:0] ram_address;
  logic        ram_write_enabled;
  logic [1:0]  ram_write_data, ram_read_data;

  logic [1:0]  mem [0:76799];
  logic [4:0]  sb [$];
  int          n_cmp, n_bad;

  fb_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .vga_req           (vga_req),
    .vga_addr          (vga_addr),
    .vga_rvalid        (vga_rvalid),
    .vga_rdata         (vga_rdata),
    .vga_miss          (vga_miss),
    .a_req             (a_req),
    .a_we              (a_we),
    .a_addr            (a_addr),
    .a_wdata           (a_wdata),
    .a_ready           (a_ready),
    .a_rvalid          (a_rvalid),
    .a_rdata           (a_rdata),
    .b_req             (b_req),
    .b_we              (b_we),
    .b_addr            (b_addr),
    .b_wdata           (b_wdata),
    .b_ready           (b_ready),
    .b_rvalid          (b_rvalid),
    .b_rdata           (b_rdata),
    .ram_address       (ram_address),
    .ram_write_enabled (ram_write_enabled),
    .ram_write_data    (ram_write_data),
    .ram_read_data     (ram_read_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM model; out-of-range addresses read back as WALL so the arbiter must mask them
  always @(posedge clock) begin
    if (reset) begin
      mem[641] <= 2'b11;
      mem[0]   <= 2'b11;
    end else if (ram_write_enabled && ram_address < 19'd76800) begin
      mem[ram_address] <= ram_write_data;
    end
    ram_read_data <= (ram_address < 19'd76800) ? mem[ram_address] : 2'b11;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // port: 0 vga read, 1 A read, 2 B read, 3 vga miss
  task automatic push(input logic [1:0] port, input logic [1:0] data);
    sb.push_back({1'b1, port, data});
  endtask

  task automatic sb_pop(input string nm, input logic [1:0] port, input logic [1:0] data);
    logic [4:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 5'b0;
    chk(nm, 32'({1'b1, port, data}), 32'(e));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    vga_req = 1'b0; a_req = 1'b0; b_req = 1'b0;
    a_we = 1'b0; b_we = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    vga_addr = 19'd641; a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    idle();

    fork
      forever begin
        @(negedge clock);
        if (!reset) begin
          if (vga_rvalid) sb_pop("sb_vga_rd", 2'd0, vga_rdata);
          if (a_rvalid)   sb_pop("sb_a_rd", 2'd1, a_rdata);
          if (b_rvalid)   sb_pop("sb_b_rd", 2'd2, b_rdata);
          if (vga_miss)   sb_pop("sb_vga_miss", 2'd3, 2'd0);
        end
      end
    join_none

    tick(); tick();
    chk("rst_rvalids", 32'({vga_rvalid, a_rvalid, b_rvalid, vga_miss}), 32'd0);
    chk("rst_ram", 32'({ram_address, ram_write_enabled, ram_write_data}), 32'd0);
    reset = 1'b0;
    tick();

    // Contention: both clients write every cycle, grants must alternate A first
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
    a_wdata = 2'b01; b_wdata = 2'b10;
    for (int i = 0; i < 6; i++) begin
      a_addr = 19'(10 + i); b_addr = 19'(20 + i);
      #1;
      chk("t2_grant", 32'({a_ready, b_ready}), (i % 2 == 0) ? 32'd2 : 32'd1);
      tick();
      chk("t2_ram_we", 32'(ram_write_enabled), 32'd1);
      chk("t2_ram_addr", 32'(ram_address), (i % 2 == 0) ? 32'(10 + i) : 32'(20 + i));
      chk("t2_ram_wdata", 32'(ram_write_data), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    idle();
    tick(); tick(); tick();

    // Solo A read of 641, latency two edges
    a_req = 1'b1; a_we = 1'b0; a_addr = 19'd641;
    #1;
    chk("t1_a_ready", 32'(a_ready), 32'd1);
    push(2'd1, 2'b11);
    tick();
    idle();
    chk("t1_ram_addr", 32'(ram_address), 32'd641);
    chk("t1_ram_we", 32'(ram_write_enabled), 32'd0);
    tick();
    chk("t1_rvalid_e1", 32'(a_rvalid), 32'd0);
    tick();
    chk("t1_rvalid_e2", 32'(a_rvalid), 32'd1);
    chk("t1_rdata", 32'(a_rdata), 32'd3);
    tick();
    chk("t1_rvalid_pulse", 32'(a_rvalid), 32'd0);

    // Starvation: VGA holds the port for 64 cycles, A forced on the 65th
    vga_req = 1'b1; vga_addr = 19'd641;
    a_req = 1'b1; a_we = 1'b1; a_addr = 19'd5; a_wdata = 2'b10;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("t4_starved", 32'(a_ready), 32'd0);
      push(2'd0, 2'b11);
      tick();
    end
    chk("t4_forced", 32'(a_ready), 32'd1);
    push(2'd3, 2'b00);
    tick();
    chk("t4_forced_addr", 32'(ram_address), 32'd5);
    chk("t4_forced_we", 32'(ram_write_enabled), 32'd1);
    a_addr = 19'd6;
    #1;
    chk("t4_cnt_cleared", 32'(a_ready), 32'd0);
    push(2'd0, 2'b11);
    tick();
    vga_req = 1'b0;
    #1;
    chk("t4_after_vga", 32'(a_ready), 32'd1);
    tick();
    idle();
    tick(); tick(); tick();

    // Out-of-range write then read by B
    b_req = 1'b1; b_we = 1'b1; b_addr = 19'd76800; b_wdata = 2'b11;
    #1;
    chk("t5_b_ready", 32'(b_ready), 32'd1);
    tick();
    chk("t5_oor_we", 32'(ram_write_enabled), 32'd0);
    chk("t5_oor_addr", 32'(ram_address), 32'd76800);
    b_we = 1'b0;
    push(2'd2, 2'b00);
    tick();
    idle();
    chk("t5_oor_rd_we", 32'(ram_write_enabled), 32'd0);
    tick(); tick(); tick();

    // A write then read of the same address back-to-back
    a_req = 1'b1; a_we = 1'b1; a_addr = 19'd0; a_wdata = 2'b01;
    tick();
    a_we = 1'b0;
    push(2'd1, 2'b01);
    tick();
    idle();
    tick(); tick(); tick();
    chk("t6_rdata", 32'(a_rdata), 32'd1);

    // Reset one cycle after an A read transfer
    a_req = 1'b1; a_we = 1'b0; a_addr = 19'd641;
    tick();
    idle();
    tick();
    reset = 1'b1;
    a_req = 1'b1; b_req = 1'b1; b_addr = 19'd641;
    #1;
    chk("t7_ready_rst", 32'({a_ready, b_ready}), 32'd0);
    chk("t7_rvalid_rst", 32'({vga_rvalid, a_rvalid, b_rvalid, vga_miss}), 32'd0);
    chk("t7_ram_rst", 32'({ram_address, ram_write_enabled, ram_write_data}), 32'd0);
    chk("t7_rdata_rst", 32'({vga_rdata, a_rdata, b_rdata}), 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("t7_tie_a", 32'({a_ready, b_ready}), 32'd2);
    push(2'd1, 2'b11);
    tick();
    a_req = 1'b0;
    #1;
    chk("t7_b_next", 32'(b_ready), 32'd1);
    push(2'd2, 2'b11);
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares the single-port 320x240, 2-bit framebuffer RAM between three requesters:
  - VGA scanout (read-only, highest priority).
  - Game logic client A (read/write).
  - Overlay/score client B (read/write).
- Sits between the requesters and the RAM and owns ram_address, ram_write_enabled and ram_write_data.
- A and B share leftover slots round-robin. A starvation guard bounds how long VGA can lock out a pending client.

Parameters:
- FB_DEPTH, 76800: number of valid pixel addresses. Addresses at or above this are out of range.
- STARVE_LIMIT, 64: consecutive cycles a client may lose to VGA before it is forced through.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- vga_req  in  1  VGA read request for this cycle
- vga_addr  in  19  VGA read address
- vga_rvalid  out  1  VGA read data valid
- vga_rdata  out  2  VGA read pixel
- vga_miss  out  1  pulse in the slot where vga_rvalid would have been; the VGA request was dropped
- a_req / b_req  in  1  client request, held until accepted
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  19  client address
- a_wdata / b_wdata  in  2  client write pixel
- a_ready / b_ready  out  1  combinational; transfer occurs on an edge where req && ready
- a_rvalid / b_rvalid  out  1  client read data valid
- a_rdata / b_rdata  out  2  client read pixel
- ram_address  out  19  to RAM
- ram_write_enabled  out  1  to RAM
- ram_write_data  out  2  to RAM
- ram_read_data  in  2  from RAM (synchronous read, 1-cycle latency)

Behaviour:
- Reset (async):
  - All outputs 0.
  - Round-robin pointer favours A.
  - Starvation counter 0.
  - In-flight read tags cleared. Pending reads are dropped and no rvalid is produced after reset.
- Arbitration (combinational, each cycle):
  - Normal case: vga_req wins. Otherwise the round-robin winner among a_req/b_req wins.
  - Forced case: starve_cnt == STARVE_LIMIT and a client is pending. The client wins even if vga_req is high.
  - Round-robin: the pointer moves to the other client after each client transfer. With only one client pending, that client wins regardless of the pointer.
  - a_ready/b_ready are high only for the winner. They do not depend on vga_req in a forced cycle.
- Starvation counter:
  - Increments on each edge where a client is pending but VGA wins.
  - Resets to 0 on any client transfer, or when no client is pending.
  - Saturates at STARVE_LIMIT.
- Issue: on the transfer edge E0, the winner's addr/we/wdata are registered onto the RAM ports for the cycle E0..E1.
  - ram_write_enabled = we && addr < FB_DEPTH.
  - Idle cycles: ram_write_enabled = 0; ram_address holds its last value.
- Read return:
  - RAM samples at E1. The arbiter registers ram_read_data and a 2-bit owner tag at E2.
  - The owner's rvalid is a one-cycle pulse during E2..E3, so read latency is 2 edges after transfer.
  - Out-of-range read: still granted, no RAM write, returns rdata = 2'b00 with normal rvalid timing.
  - Writes produce no rvalid.
- rdata outputs hold their last value when rvalid is low.
- VGA drop: vga_miss pulses, aligned to the cycle where vga_rvalid would have been, for a VGA request lost in a forced cycle.
- Throughput: one transfer per cycle, back-to-back, with no bubbles.
- Ordering: a client's write followed by its own read to the same address returns the written value, because RAM write precedes the later read.

Decomposition:
- Shared package (alongside dir_t and State):
  - fb_pixel_t enum: EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10, WALL = 2'b11.
  - FB_WIDTH = 320, FB_HEIGHT = 240, FB_DEPTH = 76800, FB_ADDR_W = 19.
  - fb_owner_t enum: NONE, VGA, CA, CB (read-tag encoding).
- Sub-module fb_rr_pick:
  - Inputs: two requests, pointer.
  - Outputs: one-hot grant.
  - Updates the pointer on the transfer strobe.

Test Plan:
- Solo client A: a_req=1, we=0, addr=641 with RAM preloaded 2'b11 at 641. Required: a_ready=1 the same cycle, ram_address=641 next cycle, a_rvalid=1 with a_rdata=2'b11 two edges after transfer.
- Contention: a_req and b_req held high with writes of 01 and 10 for 6 cycles. Required: grants alternate A,B,A,B,A,B; RAM shows 6 consecutive writes; no vga activity.
- VGA priority and starvation: vga_req held high while a_req is pending. Required: a_ready=0 for 64 cycles, a_ready=1 on the 65th, vga_miss pulses exactly once, counter clears after the transfer.
- Out-of-range: b write to addr 76800 with wdata 11, then b read of 76800. Required: ram_write_enabled stays 0; b_rvalid returns 2'b00.
- Reset mid-read: assert reset one cycle after an A read transfer. Required: all outputs 0 immediately; no a_rvalid after reset release; first post-reset A/B tie grants A.
- Write-then-read: A writes 01 to addr 0, then reads addr 0 back-to-back. Required: a_rdata = 01.
